// File: rtl/ascon_perm_scheduler_if.sv
// Request, response and permutation-core bundle for ascon_perm_scheduler.
// The slave modport is the scheduler; the master modport is the requesters, consumer and core side.
interface ascon_perm_scheduler_if;
  logic         r0_valid, r0_ready;
  logic [1:0]   r0_passes;
  logic [319:0] r0_state;
  logic         r1_valid, r1_ready;
  logic [1:0]   r1_passes;
  logic [319:0] r1_state;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [319:0] rsp_state;
  logic [319:0] core_in_s, core_out_s;
  logic [7:0]   core_a;

  modport slave (
    input  r0_valid, r0_passes, r0_state, r1_valid, r1_passes, r1_state,
           rsp_ready, core_out_s,
    output r0_ready, r1_ready, rsp_valid, rsp_id, rsp_state, core_in_s, core_a
  );
  modport master (
    output r0_valid, r0_passes, r0_state, r1_valid, r1_passes, r1_state,
           rsp_ready, core_out_s,
    input  r0_ready, r1_ready, rsp_valid, rsp_id, rsp_state, core_in_s, core_a
  );
endinterface

// File: rtl/ascon_perm_scheduler.sv
// Round-robin scheduler sharing one 4-round Ascon core between two requesters; p4/p8/p12 run as 1-3 passes.
// Define ASCON_SCHED_FIXED_PRIO_EN to make requester 0 win every contention.
module ascon_perm_scheduler #(
  parameter logic [7:0] LAST_SEED = 8'h87,
  parameter logic [7:0] SEED_STEP = 8'h3c
) (
  input logic clk,
  input logic reset,
  ascon_perm_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [319:0] st_reg;
  logic [1:0]   cnt;
  logic         id_reg, rr_ptr;

  logic [1:0]   vld;
  logic         any_vld, gnt_id;
  logic [1:0]   gnt_passes;
  logic [319:0] gnt_state;
  logic [7:0]   cnt_m1;

  assign vld        = {bus.r1_valid, bus.r0_valid};
  assign any_vld    = |vld;
  // rr_ptr stays 0 in fixed-priority builds, so the same expression gives r0 priority
  assign gnt_id     = (vld == 2'b11) ? rr_ptr : vld[1];
  assign gnt_passes = gnt_id ? bus.r1_passes : bus.r0_passes;
  assign gnt_state  = gnt_id ? bus.r1_state  : bus.r0_state;
  assign cnt_m1     = {6'd0, cnt} - 8'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = (gnt_passes != 2'd0) ? RUN : DONE;
      RUN:     if (cnt == 2'd1) state_nxt = DONE;
      DONE:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.r0_ready  = 1'b0;
    bus.r1_ready  = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = id_reg;
    bus.rsp_state = st_reg;
    bus.core_in_s = st_reg;
    bus.core_a    = 8'h00;
    case (state)
      IDLE: begin
        bus.r0_ready = any_vld & ~gnt_id & ~reset;
        bus.r1_ready = any_vld &  gnt_id & ~reset;
      end
      RUN:     bus.core_a    = LAST_SEED + SEED_STEP * cnt_m1;
      DONE:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      st_reg <= '0;
      cnt    <= '0;
      id_reg <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_vld) begin
          st_reg <= gnt_state;
          cnt    <= gnt_passes;
          id_reg <= gnt_id;
        end
        RUN: begin
          st_reg <= bus.core_out_s;
          cnt    <= cnt - 2'd1;
        end
        DONE: begin
`ifdef ASCON_SCHED_FIXED_PRIO_EN
          rr_ptr <= 1'b0;
`else
          if (bus.rsp_ready) rr_ptr <= ~id_reg;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// Bench for ascon_perm_scheduler: behavioural 4-round core, golden Ascon pN model and grant model.
module tb_ascon_perm_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0, failed = 0, total = 0;
  bit   tb_rr;

  ascon_perm_scheduler_if bus ();
  ascon_perm_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] rnd(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 ^= {56'd0, c};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 ^= ror(x0, 19) ^ ror(x0, 28);
    x1 ^= ror(x1, 61) ^ ror(x1, 39);
    x2 ^= ror(x2, 1)  ^ ror(x2, 6);
    x3 ^= ror(x3, 10) ^ ror(x3, 17);
    x4 ^= ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // permutation_4 style core: each round's constant is the seed minus 0x0f per round
  function automatic logic [319:0] core4(input logic [319:0] s, input logic [7:0] a);
    logic [7:0] rc = a;
    for (int i = 0; i < 4; i++) begin
      rc = rc - 8'h0f;
      s  = rnd(s, rc);
    end
    return s;
  endfunction

  // reference Ascon pN using the standard round-constant table for the last 4*P rounds
  function automatic logic [319:0] golden(input logic [319:0] s, input int p);
    for (int r = 12 - 4 * p; r < 12; r++) s = rnd(s, {4'(15 - r), 4'(r)});
    return s;
  endfunction

  always_comb bus.core_out_s = core4(bus.core_in_s, bus.core_a);

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_op(input logic [1:0] vmask, input bit exp_id, input logic [1:0] p0, p1,
                        input logic [319:0] s0, s1, input int delay, input bit keep,
                        input bit clr);
    logic [7:0]   seeds [3] = '{8'hff, 8'hc3, 8'h87};
    int           p;
    logic [319:0] exp_s;
    p     = exp_id ? int'(p1) : int'(p0);
    exp_s = golden(exp_id ? s1 : s0, p);
    bus.r0_valid = vmask[0]; bus.r0_passes = p0; bus.r0_state = s0;
    bus.r1_valid = vmask[1]; bus.r1_passes = p1; bus.r1_state = s1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("grant_r0_ready", 320'(bus.r0_ready), 320'(!exp_id));
    chk("grant_r1_ready", 320'(bus.r1_ready), 320'(exp_id));
    chk("idle_core_a", 320'(bus.core_a), 320'h0);
    chk("idle_rsp_valid", 320'(bus.rsp_valid), 320'h0);
    if (clr) begin
      chk("post_reset_st_reg", dut.st_reg, 320'h0);
      chk("post_reset_cnt", 320'(dut.cnt), 320'h0);
    end
    step();
    if (!keep) begin bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; end
    bus.r0_state = rand320(); bus.r1_state = rand320();
    bus.r0_passes = 2'($urandom); bus.r1_passes = 2'($urandom);
    for (int k = 1; k <= p; k++) begin
      @(negedge clk);
      chk("run_core_a", 320'(bus.core_a), 320'(seeds[3 - p + k - 1]));
      chk("run_rsp_valid", 320'(bus.rsp_valid), 320'h0);
      chk("run_readies", 320'({bus.r1_ready, bus.r0_ready}), 320'h0);
      step();
    end
    for (int d = 0; d <= delay; d++) begin
      @(negedge clk);
      chk("done_rsp_valid", 320'(bus.rsp_valid), 320'h1);
      chk("done_rsp_id", 320'(bus.rsp_id), 320'(exp_id));
      chk("done_rsp_state", bus.rsp_state, exp_s);
      chk("done_readies", 320'({bus.r1_ready, bus.r0_ready}), 320'h0);
      chk("done_core_a", 320'(bus.core_a), 320'h0);
      if (d == delay) bus.rsp_ready = 1'b1;
      step();
    end
    bus.rsp_ready = 1'b0;
`ifdef ASCON_SCHED_FIXED_PRIO_EN
    tb_rr = 1'b0;
`else
    tb_rr = ~exp_id;
`endif
  endtask

  task automatic do_reset();
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    bus.r0_passes = 2'd3; bus.r1_passes = 2'd3;
    reset = 1'b1;
    step(); step();
    @(negedge clk);
    chk("reset_rsp_valid", 320'(bus.rsp_valid), 320'h0);
    chk("reset_readies", 320'({bus.r1_ready, bus.r0_ready}), 320'h0);
    chk("reset_core_a", 320'(bus.core_a), 320'h0);
    chk("reset_st_reg", dut.st_reg, 320'h0);
    step();
    reset = 1'b0;
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    tb_rr = 1'b0;
  endtask

  initial begin
    logic [319:0] iv_kn, a, b;
    logic [1:0]   vm;
    bit           eid;
    bus.rsp_ready = 1'b0;
    bus.r0_state = '0; bus.r1_state = '0;
    do_reset();

    iv_kn = {64'h80800c0800000000, rand320()};
    iv_kn[319:256] = 64'h80800c0800000000;
    run_op(2'b01, 1'b0, 2'd3, 2'd0, iv_kn, '0, 0, 1'b0, 1'b0);
    run_op(2'b10, 1'b1, 2'd0, 2'd2, rand320(), rand320(), 0, 1'b0, 1'b0);
    run_op(2'b10, 1'b1, 2'd0, 2'd1, rand320(), rand320(), 0, 1'b0, 1'b0);
    run_op(2'b01, 1'b0, 2'd0, 2'd3, 320'h1234, rand320(), 0, 1'b0, 1'b0);
    run_op(2'b01, 1'b0, 2'd2, 2'd0, rand320(), rand320(), 5, 1'b0, 1'b0);

    do_reset();
    for (int n = 0; n < 4; n++) begin
      eid = tb_rr;
      run_op(2'b11, eid, 2'd3, 2'd3, rand320(), rand320(), 0, 1'b1, 1'b0);
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;

    for (int n = 0; n < 10; n++) begin
      vm  = 2'($urandom_range(1, 3));
      eid = (vm == 2'b11) ? tb_rr : vm[1];
      a   = rand320(); b = rand320();
      run_op(vm, eid, 2'($urandom), 2'($urandom), a, b, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    bus.r0_valid = 1'b1; bus.r0_passes = 2'd3; bus.r0_state = rand320();
    bus.r1_valid = 1'b0;
    step();
    bus.r0_valid = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_2nd_run_core_a", 320'(bus.core_a), 320'hc3);
    step();
    reset = 1'b0;
    tb_rr = 1'b0;
    run_op(2'b10, 1'b1, 2'd0, 2'd1, rand320(), rand320(), 1, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("no_stale_rsp", 320'(bus.rsp_valid), 320'h0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ascon_perm_scheduler.md
Name: ascon_perm_scheduler

Overview:
Shares one combinational 4-round Ascon permutation core (`permutation_4` style: 320-bit state in, round-seed byte `a`, 320-bit state out) between two requesters, e.g. an AEAD engine and a hash engine. It grants requesters round-robin and sequences p^4/p^8/p^12 as 1/2/3 core passes, one pass per clock, with the correct round-constant seed per pass. The result returns on a valid/ready response channel tagged with the requester id.

Parameters:
- `LAST_SEED`, 8'h87: seed byte of the final pass of every operation.
- `SEED_STEP`, 8'h3c: seed increment per earlier pass. Seeds are 8'hff, 8'hc3, 8'h87.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `r0_valid`  in  1  requester 0 request
- `r0_ready`  out  1  requester 0 accepted this cycle
- `r0_passes`  in  2  number of 4-round passes: 1=p4, 2=p8, 3=p12, 0=bypass
- `r0_state`  in  320  input state {x0,x1,x2,x3,x4}, x0 in [319:256]
- `r1_valid`, `r1_ready`, `r1_passes`, `r1_state`: as requester 0
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  requester that owns the result
- `rsp_state`  out  320  permuted state
- `core_in_s`  out  320  state to core
- `core_a`  out  8  seed byte to core
- `core_out_s`  in  320  core output (combinational from `core_in_s`/`core_a`)

Behaviour:
- Registers: `st_reg`[319:0], `cnt`[1:0] (passes remaining), `id_reg`, `rr_ptr`, FSM `{IDLE, RUN, DONE}`.
- Reset:
  - FSM=IDLE; `st_reg`=0, `cnt`=0, `id_reg`=0, `rr_ptr`=0.
  - `rsp_valid`=0, `r0_ready`=`r1_ready`=0, `core_a`=8'h00.
- Reset mid-operation discards the operation. No response is issued and no ready is re-asserted for it.
- Ready outputs are combinational. In IDLE only, exactly one of `r0_ready`/`r1_ready` is high, for the granted valid requester. Both are 0 in RUN and DONE.
- Grant in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: requester `rr_ptr` is granted.
  - Acceptance (valid&ready) latches `st_reg`<=state, `cnt`<=passes, `id_reg`<=id.
  - Next state is RUN if passes!=0, otherwise DONE (bypass: response equals input state).
- RUN:
  - `core_in_s`=`st_reg`; `core_a`=`LAST_SEED` + `SEED_STEP`*(`cnt`-1), truncated to 8 bits.
  - Each cycle: `st_reg`<=`core_out_s`, `cnt`<=`cnt`-1. When `cnt`==1, go to DONE.
  - Sequences: p12 seeds ff,c3,87; p8 seeds c3,87; p4 seed 87.
- Outside RUN: `core_in_s`=`st_reg`, `core_a`=8'h00. Core output is ignored.
- DONE:
  - `rsp_valid`=1, `rsp_state`=`st_reg`, `rsp_id`=`id_reg`.
  - These hold stable while `rsp_ready`=0.
  - On `rsp_valid`&`rsp_ready`: go to IDLE and set `rr_ptr`<=~`id_reg`.
- Latency: with acceptance in cycle 0, `rsp_valid` rises in cycle P+1 (P=passes; bypass gives cycle 1). The earliest next acceptance is the cycle after the response handshake. There is no overlap.
- Request inputs are sampled only at acceptance. Changes to `rN_state`/`rN_passes` afterwards have no effect.
- A requester dropping valid before being granted is legal. It is not granted.

Optional Feature:
- Macro `ASCON_SCHED_FIXED_PRIO_EN`.
- Defined: requester 0 always wins when both are valid. `rr_ptr` is held at 0 and never updated.
- Undefined: round-robin as specified above.

Test Plan:
- Only r0 valid, passes=3, state={IV=64'h80800c0800000000,K,N}:
  - `r0_ready` is high in cycle 0.
  - `core_a` is ff,c3,87 in cycles 1-3.
  - `rsp_valid` rises in cycle 4 with `rsp_id`=0.
  - `rsp_state` equals the golden p12 model output.
- r1 alone, passes=2: seeds c3,87; `rsp_valid` in cycle 3; `rsp_id`=1; state equals golden p8. Repeat with passes=1: seed 87; `rsp_valid` in cycle 2.
- Both valid continuously, passes=3:
  - Grants alternate 0,1,0,1, starting with 0 after reset.
  - With `ASCON_SCHED_FIXED_PRIO_EN`, all grants go to 0.
- Backpressure: `rsp_ready`=0 for 5 cycles in DONE.
  - `rsp_valid`/`rsp_state`/`rsp_id` stay stable.
  - Both readies stay 0 and `core_a`=00.
  - The release cycle completes the handshake, and the next grant occurs in the following cycle.
- passes=0 with state=320'h1234: `rsp_valid` in cycle 1, `rsp_state`=320'h1234, `core_a` stays 00.
- `reset` asserted in the 2nd RUN cycle of p12:
  - The next cycle shows IDLE, `rsp_valid`=0, `st_reg`=0.
  - No response is ever produced for the aborted operation.
  - A new request is accepted immediately after reset deasserts.
